// File: rtl/threshold_mask_stats.sv
// rtl/threshold_mask_stats.sv - N-channel window threshold, AND-combined mask and per-frame count
//
// Purpose:
//   Tests each pixel channel against its own (lower, upper] window with optional
//   inversion, ANDs the channel results into one mask bit (latency 2), and counts
//   masked pixels per frame. Bounds are double-buffered (shadow -> active) and the
//   copy happens only on a frame-end pixel.
//
// Ports:
//   clk_in, rst_in              clock, synchronous active-high reset
//   valid_in, pixel_in          pixel stream (channel c at [c*WIDTH +: WIDTH])
//   frame_end_in                marks the last pixel of a frame (with valid_in)
//   cfg_we_in, cfg_chan_in      shadow bound write enable and target channel
//   cfg_lower_in, cfg_upper_in  shadow window (lower exclusive, upper inclusive)
//   cfg_invert_in               shadow invert flag
//   cfg_commit_in               request shadow->active copy at the next frame end
//   valid_out, mask_out         mask result and its qualifier
//   chan_mask_out               per-channel results after inversion
//   frame_end_out               frame end aligned with valid_out
//   count_out, count_valid_out  masked-pixel count of the last frame and update pulse
//   cfg_pending_out             commit requested but not yet applied

module threshold_mask_stats #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 20,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      valid_in,
  input  logic [CHANNELS*WIDTH-1:0] pixel_in,
  input  logic                      frame_end_in,
  input  logic                      cfg_we_in,
  input  logic [CHAN_W-1:0]         cfg_chan_in,
  input  logic [WIDTH-1:0]          cfg_lower_in,
  input  logic [WIDTH-1:0]          cfg_upper_in,
  input  logic                      cfg_invert_in,
  input  logic                      cfg_commit_in,
  output logic                      valid_out,
  output logic                      mask_out,
  output logic [CHANNELS-1:0]       chan_mask_out,
  output logic                      frame_end_out,
  output logic [COUNT_WIDTH-1:0]    count_out,
  output logic                      count_valid_out,
  output logic                      cfg_pending_out
);

  logic [CHANNELS-1:0][WIDTH-1:0] act_lower;
  logic [CHANNELS-1:0][WIDTH-1:0] act_upper;
  logic [CHANNELS-1:0]            act_invert;
  logic [CHANNELS-1:0][WIDTH-1:0] sh_lower;
  logic [CHANNELS-1:0][WIDTH-1:0] sh_upper;
  logic [CHANNELS-1:0]            sh_invert;

  logic [CHANNELS-1:0]    chan_now;
  logic                   apply;
  logic                   we_ok;

  logic                   s1_valid;
  logic                   s1_fe;
  logic [CHANNELS-1:0]    s1_chan;
  logic [COUNT_WIDTH-1:0] acc;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic inc);
    if (inc && !(&a)) begin
      return a + COUNT_WIDTH'(1);
    end
    return a;
  endfunction

  // Window test against the active bounds. An empty window (lower >= upper)
  // never hits, so the channel result reduces to the invert flag.
  always_comb begin
    chan_now = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chan_now[c] = ((pixel_in[c*WIDTH +: WIDTH] > act_lower[c]) &&
                     (pixel_in[c*WIDTH +: WIDTH] <= act_upper[c])) ^ act_invert[c];
    end
  end

  // A commit arriving together with the frame-end pixel applies immediately.
  assign apply = valid_in && frame_end_in && (cfg_pending_out || cfg_commit_in);
  assign we_ok = cfg_we_in && (32'(cfg_chan_in) < 32'(CHANNELS));

  // Active copy takes the shadow value from before this cycle's write, so a
  // write in the apply cycle waits for a later commit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      act_lower       <= '0;
      act_upper       <= '1;
      act_invert      <= '0;
      sh_lower        <= '0;
      sh_upper        <= '1;
      sh_invert       <= '0;
      cfg_pending_out <= 1'b0;
    end else begin
      if (apply) begin
        act_lower  <= sh_lower;
        act_upper  <= sh_upper;
        act_invert <= sh_invert;
      end
      if (we_ok) begin
        sh_lower[cfg_chan_in]  <= cfg_lower_in;
        sh_upper[cfg_chan_in]  <= cfg_upper_in;
        sh_invert[cfg_chan_in] <= cfg_invert_in;
      end
      if (apply) begin
        cfg_pending_out <= 1'b0;
      end else if (cfg_commit_in) begin
        cfg_pending_out <= 1'b1;
      end
    end
  end

  // Two-stage pipeline; data registers load only on valid so outputs hold
  // through bubbles, while the frame-end flag is qualified to pulse once.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid      <= 1'b0;
      s1_fe         <= 1'b0;
      s1_chan       <= '0;
      valid_out     <= 1'b0;
      mask_out      <= 1'b0;
      chan_mask_out <= '0;
      frame_end_out <= 1'b0;
    end else begin
      s1_valid      <= valid_in;
      s1_fe         <= valid_in && frame_end_in;
      if (valid_in) begin
        s1_chan <= chan_now;
      end
      valid_out     <= s1_valid;
      frame_end_out <= s1_valid && s1_fe;
      if (s1_valid) begin
        chan_mask_out <= s1_chan;
        mask_out      <= &s1_chan;
      end
    end
  end

  // The accumulator works from stage-1 values (identical to the mask about to
  // be presented) so count_valid_out lines up with frame_end_out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc             <= '0;
      count_out       <= '0;
      count_valid_out <= 1'b0;
    end else begin
      count_valid_out <= 1'b0;
      if (s1_valid && s1_fe) begin
        count_out       <= sat_inc(acc, &s1_chan);
        count_valid_out <= 1'b1;
        acc             <= '0;
      end else if (s1_valid && (&s1_chan)) begin
        acc <= sat_inc(acc, 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_threshold_mask_stats.sv
// tb/tb_threshold_mask_stats.sv - self-checking bench for threshold_mask_stats

module tb_threshold_mask_stats;
  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int CW  = 20;
  localparam int CWS = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in;
  logic          valid_in;
  logic [CH*W-1:0] pixel_in;
  logic          frame_end_in;
  logic          cfg_we_in;
  logic [0:0]    cfg_chan_in;
  logic [W-1:0]  cfg_lower_in;
  logic [W-1:0]  cfg_upper_in;
  logic          cfg_invert_in;
  logic          cfg_commit_in;

  logic          valid_out, mask_out, frame_end_out, count_valid_out, cfg_pending_out;
  logic [CH-1:0] chan_mask_out;
  logic [CW-1:0] count_out;

  logic          s_valid_out, s_mask_out, s_frame_end_out, s_count_valid_out, s_cfg_pending_out;
  logic [CH-1:0] s_chan_mask_out;
  logic [CWS-1:0] s_count_out;

  threshold_mask_stats #(.CHANNELS(CH), .WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .pixel_in(pixel_in),
    .frame_end_in(frame_end_in), .cfg_we_in(cfg_we_in), .cfg_chan_in(cfg_chan_in),
    .cfg_lower_in(cfg_lower_in), .cfg_upper_in(cfg_upper_in), .cfg_invert_in(cfg_invert_in),
    .cfg_commit_in(cfg_commit_in), .valid_out(valid_out), .mask_out(mask_out),
    .chan_mask_out(chan_mask_out), .frame_end_out(frame_end_out), .count_out(count_out),
    .count_valid_out(count_valid_out), .cfg_pending_out(cfg_pending_out)
  );

  threshold_mask_stats #(.CHANNELS(CH), .WIDTH(W), .COUNT_WIDTH(CWS)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .pixel_in(pixel_in),
    .frame_end_in(frame_end_in), .cfg_we_in(cfg_we_in), .cfg_chan_in(cfg_chan_in),
    .cfg_lower_in(cfg_lower_in), .cfg_upper_in(cfg_upper_in), .cfg_invert_in(cfg_invert_in),
    .cfg_commit_in(cfg_commit_in), .valid_out(s_valid_out), .mask_out(s_mask_out),
    .chan_mask_out(s_chan_mask_out), .frame_end_out(s_frame_end_out), .count_out(s_count_out),
    .count_valid_out(s_count_valid_out), .cfg_pending_out(s_cfg_pending_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int  act_lo [CH];
  int  act_hi [CH];
  bit  act_inv [CH];
  int  sh_lo [CH];
  int  sh_hi [CH];
  bit  sh_inv [CH];
  bit  pending;
  int  frame_cnt;

  typedef struct {
    bit       v;
    bit [1:0] chan;
    bit       fe;
    int       cnt;
  } pred_t;
  pred_t prev;

  bit       h_mask;
  bit [1:0] h_chan;
  int       h_cnt, h_cnt_s;

  logic [2:0] obs [$];
  int n_pulse, last_cnt, last_cnt_s;

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    logic       m;
    logic [1:0] chan;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      act_lo[c] = 0; act_hi[c] = 255; act_inv[c] = 1'b0;
      sh_lo[c]  = 0; sh_hi[c]  = 255; sh_inv[c]  = 1'b0;
    end
    pending   = 1'b0;
    frame_cnt = 0;
  endtask

  task automatic idle();
    rst_in = 1'b0; valid_in = 1'b0; frame_end_in = 1'b0;
    cfg_we_in = 1'b0; cfg_commit_in = 1'b0;
  endtask

  // One clock: predict from the current inputs, advance, then compare every
  // output with what the model says should be visible after this edge.
  task automatic tick();
    pred_t    p;
    bit [1:0] ch;
    bit       was_rst, ap, ev, efe, ecv;
    int       pv;
    was_rst = rst_in;
    for (int c = 0; c < CH; c++) begin
      pv = int'(pixel_in[c*W +: W]);
      ch[c] = ((pv > act_lo[c]) && (pv <= act_hi[c])) ^ act_inv[c];
    end
    p.v = valid_in; p.chan = ch; p.fe = frame_end_in; p.cnt = 0;
    if (was_rst) begin
      model_reset();
      p.v = 1'b0;
    end else begin
      if (valid_in && (&ch)) frame_cnt++;
      if (valid_in && frame_end_in) begin
        p.cnt = frame_cnt;
        frame_cnt = 0;
      end
      ap = valid_in && frame_end_in && (pending || cfg_commit_in);
      if (ap) begin
        for (int c = 0; c < CH; c++) begin
          act_lo[c] = sh_lo[c]; act_hi[c] = sh_hi[c]; act_inv[c] = sh_inv[c];
        end
        pending = 1'b0;
      end else if (cfg_commit_in) begin
        pending = 1'b1;
      end
      if (cfg_we_in && (int'(cfg_chan_in) < CH)) begin
        sh_lo[cfg_chan_in]  = int'(cfg_lower_in);
        sh_hi[cfg_chan_in]  = int'(cfg_upper_in);
        sh_inv[cfg_chan_in] = cfg_invert_in;
      end
    end

    @(posedge clk_in);
    #1;

    ev = 1'b0; efe = 1'b0; ecv = 1'b0;
    if (was_rst) begin
      h_mask = 1'b0; h_chan = 2'b00; h_cnt = 0; h_cnt_s = 0;
    end else if (prev.v) begin
      ev = 1'b1;
      h_mask = &prev.chan;
      h_chan = prev.chan;
      efe = prev.fe;
      if (prev.fe) begin
        ecv = 1'b1;
        h_cnt = sat(prev.cnt, CW);
        h_cnt_s = sat(prev.cnt, CWS);
      end
    end
    prev = p;

    chk("valid_out", valid_out, ev);
    chk("mask_out", mask_out, h_mask);
    chk("chan_mask_out", chan_mask_out, h_chan);
    chk("frame_end_out", frame_end_out, efe);
    chk("count_valid_out", count_valid_out, ecv);
    chk("count_out", count_out, h_cnt);
    chk("cfg_pending_out", cfg_pending_out, pending);
    chk("s_valid_out", s_valid_out, ev);
    chk("s_mask_out", s_mask_out, h_mask);
    chk("s_count_valid_out", s_count_valid_out, ecv);
    chk("s_count_out", s_count_out, h_cnt_s);

    if (valid_out) obs.push_back({mask_out, chan_mask_out});
    if (count_valid_out) begin
      n_pulse++;
      last_cnt = int'(count_out);
      last_cnt_s = int'(s_count_out);
    end
  endtask

  task automatic flush();
    idle();
    repeat (3) tick();
  endtask

  task automatic pix(input logic [7:0] a, input logic [7:0] b, input logic fe);
    valid_in = 1'b1; pixel_in = {b, a}; frame_end_in = fe;
    tick();
    idle();
  endtask

  task automatic cfg(input logic c, input logic [7:0] lo, input logic [7:0] hi, input logic inv);
    cfg_we_in = 1'b1; cfg_chan_in = c; cfg_lower_in = lo; cfg_upper_in = hi; cfg_invert_in = inv;
    tick();
    idle();
  endtask

  task automatic commit();
    cfg_commit_in = 1'b1;
    tick();
    idle();
  endtask

  task automatic run_tbl(input int base, input int n);
    obs.delete();
    for (int i = 0; i < n; i++) pix(tbl[base+i].p0, tbl[base+i].p1, 1'b0);
    flush();
    chk($sformatf("tbl%0d_count", base), obs.size(), n);
    for (int j = 0; j < n; j++) begin
      if (j < obs.size()) begin
        chk($sformatf("tbl%0d_mask", base + j), obs[j][2], tbl[base+j].m);
        chk($sformatf("tbl%0d_chan", base + j), obs[j][1:0], tbl[base+j].chan);
      end
    end
  endtask

  initial begin
    tbl[0] = '{8'd0,   8'd0,   1'b0, 2'b00};
    tbl[1] = '{8'd1,   8'd1,   1'b1, 2'b11};
    tbl[2] = '{8'd255, 8'd255, 1'b1, 2'b11};
    tbl[3] = '{8'd10,  8'd150, 1'b0, 2'b10};
    tbl[4] = '{8'd11,  8'd150, 1'b1, 2'b11};
    tbl[5] = '{8'd20,  8'd200, 1'b1, 2'b11};
    tbl[6] = '{8'd21,  8'd150, 1'b0, 2'b10};
    tbl[7] = '{8'd15,  8'd150, 1'b0, 2'b01};
    tbl[8] = '{8'd15,  8'd50,  1'b1, 2'b11};

    prev = '{v: 1'b0, chan: 2'b00, fe: 1'b0, cnt: 0};
    h_mask = 1'b0; h_chan = 2'b00; h_cnt = 0; h_cnt_s = 0;
    n_pulse = 0; last_cnt = 0; last_cnt_s = 0;
    model_reset();
    idle();
    pixel_in = '0; cfg_chan_in = 1'b0; cfg_lower_in = '0; cfg_upper_in = '0; cfg_invert_in = 1'b0;
    rst_in = 1'b1;
    tick(); tick();
    idle();

    // Reset defaults and exact two-cycle latency
    chk("reset_count", count_out, 0);
    valid_in = 1'b1; pixel_in = {8'd1, 8'd1};
    tick();
    idle();
    chk("lat_edge1_valid", valid_out, 0);
    tick();
    chk("lat_edge2_valid", valid_out, 1);
    chk("lat_edge2_mask", mask_out, 1);
    flush();
    run_tbl(0, 3);

    // Windows ch0 (10,20], ch1 (100,200]
    cfg(1'b0, 8'd10, 8'd20, 1'b0);
    cfg(1'b1, 8'd100, 8'd200, 1'b0);
    commit();
    chk("t2_pend_set", cfg_pending_out, 1);
    pix(8'd0, 8'd0, 1'b1);
    chk("t2_pend_clr", cfg_pending_out, 0);
    flush();
    run_tbl(3, 4);

    // ch1 inverted
    cfg(1'b1, 8'd100, 8'd200, 1'b1);
    commit();
    pix(8'd0, 8'd0, 1'b1);
    flush();
    run_tbl(7, 2);

    // Mid-frame commit, plus a shadow write in the apply cycle
    cfg(1'b0, 8'd0, 8'd255, 1'b0);
    commit();
    obs.delete();
    pix(8'd5, 8'd50, 1'b0);
    chk("t4_pend_mid", cfg_pending_out, 1);
    valid_in = 1'b1; pixel_in = {8'd50, 8'd5}; frame_end_in = 1'b1;
    cfg_we_in = 1'b1; cfg_chan_in = 1'b1; cfg_lower_in = 8'd0; cfg_upper_in = 8'd0; cfg_invert_in = 1'b0;
    tick();
    idle();
    chk("t4_pend_after_fe", cfg_pending_out, 0);
    pix(8'd5, 8'd50, 1'b1);
    flush();
    chk("t4_obs_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("t4_old_mid", obs[0], 3'b010);
      chk("t4_old_fe", obs[1], 3'b010);
      chk("t4_new_first", obs[2], 3'b111);
    end

    // Frame of 7 with 5 masked (last masked), bubble inside
    n_pulse = 0;
    pix(8'd5, 8'd50, 1'b0);
    pix(8'd5, 8'd150, 1'b0);
    pix(8'd5, 8'd50, 1'b0);
    tick();
    pix(8'd5, 8'd50, 1'b0);
    pix(8'd5, 8'd150, 1'b0);
    pix(8'd5, 8'd50, 1'b0);
    pix(8'd5, 8'd50, 1'b1);
    flush();
    chk("t5_pulses", n_pulse, 1);
    chk("t5_count", last_cnt, 5);
    pix(8'd5, 8'd50, 1'b0);
    pix(8'd5, 8'd150, 1'b1);
    flush();
    chk("t5_next_pulses", n_pulse, 2);
    chk("t5_next_count", last_cnt, 1);

    // Saturation, then reset mid-frame
    n_pulse = 0;
    for (int i = 0; i < 10; i++) pix(8'd5, 8'd50, (i == 9));
    flush();
    chk("t6_pulses", n_pulse, 1);
    chk("t6_sat_count", last_cnt_s, 7);
    chk("t6_wide_count", last_cnt, 10);
    for (int i = 0; i < 3; i++) pix(8'd5, 8'd50, 1'b0);
    rst_in = 1'b1; valid_in = 1'b1; pixel_in = {8'd50, 8'd5}; frame_end_in = 1'b1;
    tick();
    idle();
    flush();
    chk("t6_no_pulse_after_rst", n_pulse, 1);
    chk("t6_count_cleared", count_out, 0);
    for (int i = 0; i < 4; i++) pix(8'd5, 8'd5, (i == 3));
    flush();
    chk("t6_after_rst_pulses", n_pulse, 2);
    chk("t6_after_rst_count", last_cnt, 4);
    chk("t6_after_rst_count_s", last_cnt_s, 4);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst_in        = ($urandom_range(0, 199) == 0);
      valid_in      = ($urandom_range(0, 3) != 0);
      pixel_in      = CH*W'($urandom);
      frame_end_in  = ($urandom_range(0, 7) == 0);
      cfg_we_in     = ($urandom_range(0, 7) == 0);
      cfg_chan_in   = 1'($urandom_range(0, 1));
      cfg_lower_in  = 8'($urandom_range(0, 128));
      cfg_upper_in  = 8'($urandom_range(64, 255));
      cfg_invert_in = ($urandom_range(0, 3) == 0);
      cfg_commit_in = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
